filter_scan_ctrl: RTL and testbench

FILTER_SCAN_CTRL -- requirements
Module: filter_scan_ctrl

---
 rtl/filter_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_filter_scan_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// filter_scan_ctrl : raster scan of 3x3 windows with a 1/9 mean filter.
// Rev 1.0
// ---------------------------------------------------------------------------
module filter_scan_ctrl #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] sw_pixel_1,
  input  logic [7:0] sw_pixel_2,
  input  logic [7:0] sw_pixel_3,
  input  logic [7:0] sw_pixel_4,
  input  logic [7:0] sw_pixel_5,
  input  logic [7:0] sw_pixel_6,
  input  logic [7:0] sw_pixel_7,
  input  logic [7:0] sw_pixel_8,
  input  logic [7:0] sw_pixel_9,
  output logic       rd,
  output logic [7:0] addr_row_r,
  output logic [7:0] addr_col_r,
  output logic       wr,
  output logic [7:0] addr_row_w,
  output logic [7:0] addr_col_w,
  output logic [7:0] cl_pixel,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    CALC  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [7:0] COL_LAST  = 8'(IMG_W - 3);
  localparam logic [7:0] ROW_LAST  = 8'(IMG_H - 3);
  localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 1);

  state_t      state, state_n;
  logic [7:0]  row, col, row_n, col_n;
  logic [2:0]  wait_cnt, wait_cnt_n;
  logic [11:0] sum, sum_n;

  assign sum_n = {4'd0, sw_pixel_1} + {4'd0, sw_pixel_2} + {4'd0, sw_pixel_3}
               + {4'd0, sw_pixel_4} + {4'd0, sw_pixel_5} + {4'd0, sw_pixel_6}
               + {4'd0, sw_pixel_7} + {4'd0, sw_pixel_8} + {4'd0, sw_pixel_9};

  // 57/512 approximates 1/9; the 8-bit quotient field already caps at 255.
  assign cl_pixel = 8'(({5'd0, sum} * 17'd57) >> 9);

  always_comb begin
    state_n    = state;
    row_n      = row;
    col_n      = col;
    wait_cnt_n = wait_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = READ;
          row_n   = 8'd0;
          col_n   = 8'd0;
        end
      end
      READ: begin
        state_n    = WAIT;
        wait_cnt_n = 3'd0;
      end
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_n = CALC;
        end else begin
          wait_cnt_n = wait_cnt + 3'd1;
        end
      end
      CALC: state_n = WRITE;
      WRITE: begin
        if (row == ROW_LAST && col == COL_LAST) begin
          state_n = DONE;
        end else begin
          state_n = READ;
          if (col < COL_LAST) begin
            col_n = col + 8'd1;
          end else begin
            col_n = 8'd0;
            row_n = row + 8'd1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row        <= 8'd0;
      col        <= 8'd0;
      wait_cnt   <= 3'd0;
      sum        <= 12'd0;
      addr_row_r <= 8'd0;
      addr_col_r <= 8'd0;
      addr_row_w <= 8'd0;
      addr_col_w <= 8'd0;
    end else begin
      state    <= state_n;
      row      <= row_n;
      col      <= col_n;
      wait_cnt <= wait_cnt_n;
      if (state == CALC) begin
        sum <= sum_n;
      end
      // Address buses only move when their strobe is about to fire.
      if (state_n == READ) begin
        addr_row_r <= row_n;
        addr_col_r <= col_n;
      end
      if (state_n == WRITE) begin
        addr_row_w <= row + 8'd1;
        addr_col_w <= col + 8'd1;
      end
    end
  end

  assign rd   = (state == READ);
  assign wr   = (state == WRITE);
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_filter_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_filter_scan_ctrl : directed bench over three parameter sets.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_filter_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_a, start_b, start_c;
  logic [7:0] pix [9];

  logic       rd_a, wr_a, busy_a, done_a, rd_b, wr_b, busy_b, done_b, rd_c, wr_c, busy_c, done_c;
  logic [7:0] arr_a, acr_a, arw_a, acw_a, cl_a;
  logic [7:0] arr_b, acr_b, arw_b, acw_b, cl_b;
  logic [7:0] arr_c, acr_c, arw_c, acw_c, cl_c;

  filter_scan_ctrl #(.IMG_W(4), .IMG_H(4), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .sw_pixel_1(pix[0]), .sw_pixel_2(pix[1]), .sw_pixel_3(pix[2]),
    .sw_pixel_4(pix[3]), .sw_pixel_5(pix[4]), .sw_pixel_6(pix[5]),
    .sw_pixel_7(pix[6]), .sw_pixel_8(pix[7]), .sw_pixel_9(pix[8]),
    .rd(rd_a), .addr_row_r(arr_a), .addr_col_r(acr_a),
    .wr(wr_a), .addr_row_w(arw_a), .addr_col_w(acw_a),
    .cl_pixel(cl_a), .busy(busy_a), .done(done_a));

  filter_scan_ctrl #(.IMG_W(4), .IMG_H(4), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .sw_pixel_1(pix[0]), .sw_pixel_2(pix[1]), .sw_pixel_3(pix[2]),
    .sw_pixel_4(pix[3]), .sw_pixel_5(pix[4]), .sw_pixel_6(pix[5]),
    .sw_pixel_7(pix[6]), .sw_pixel_8(pix[7]), .sw_pixel_9(pix[8]),
    .rd(rd_b), .addr_row_r(arr_b), .addr_col_r(acr_b),
    .wr(wr_b), .addr_row_w(arw_b), .addr_col_w(acw_b),
    .cl_pixel(cl_b), .busy(busy_b), .done(done_b));

  filter_scan_ctrl #(.IMG_W(256), .IMG_H(3), .RD_LAT(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c),
    .sw_pixel_1(pix[0]), .sw_pixel_2(pix[1]), .sw_pixel_3(pix[2]),
    .sw_pixel_4(pix[3]), .sw_pixel_5(pix[4]), .sw_pixel_6(pix[5]),
    .sw_pixel_7(pix[6]), .sw_pixel_8(pix[7]), .sw_pixel_9(pix[8]),
    .rd(rd_c), .addr_row_r(arr_c), .addr_col_r(acr_c),
    .wr(wr_c), .addr_row_w(arw_c), .addr_col_w(acw_c),
    .cl_pixel(cl_c), .busy(busy_c), .done(done_c));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event logs, sampled on the falling edge
  int a_rd_t[$], a_rd_r[$], a_rd_c[$], a_wr_t[$], a_wr_r[$], a_wr_c[$], a_wr_p[$], a_done_t[$];
  int b_rd_t[$], b_wr_t[$], b_wr_p[$], b_done_t[$];
  int overlap_n = 0;
  int c_wr_n = 0, c_wr_maxcol = 0, c_row_bad = 0, c_seq_bad = 0, c_cl_bad = 0;
  int c_rd_maxcol = 0, c_rd_row_bad = 0, c_done_n = 0;

  always @(negedge clk) begin
    if (rd_a) begin a_rd_t.push_back(cyc); a_rd_r.push_back(int'(arr_a)); a_rd_c.push_back(int'(acr_a)); end
    if (wr_a) begin
      a_wr_t.push_back(cyc); a_wr_r.push_back(int'(arw_a));
      a_wr_c.push_back(int'(acw_a)); a_wr_p.push_back(int'(cl_a));
    end
    if (done_a) a_done_t.push_back(cyc);
    if (rd_b) b_rd_t.push_back(cyc);
    if (wr_b) begin b_wr_t.push_back(cyc); b_wr_p.push_back(int'(cl_b)); end
    if (done_b) b_done_t.push_back(cyc);
    if ((rd_a && wr_a) || (rd_b && wr_b) || (rd_c && wr_c)) overlap_n <= overlap_n + 1;
    if (rd_c) begin
      if (int'(acr_c) > c_rd_maxcol) c_rd_maxcol <= int'(acr_c);
      if (arr_c != 8'd0) c_rd_row_bad <= c_rd_row_bad + 1;
    end
    if (wr_c) begin
      c_wr_n <= c_wr_n + 1;
      if (int'(acw_c) > c_wr_maxcol) c_wr_maxcol <= int'(acw_c);
      if (arw_c != 8'd1) c_row_bad <= c_row_bad + 1;
      if (int'(acw_c) != c_wr_n + 1) c_seq_bad <= c_seq_bad + 1;
      if (cl_c != 8'd100) c_cl_bad <= c_cl_bad + 1;
    end
    if (done_c) c_done_n <= c_done_n + 1;
  end

  int checks = 0;
  int errors = 0;
  int s_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int v);
    for (int i = 0; i < 9; i++) pix[i] = 8'(v);
  endtask

  function automatic int done_cnt(input int which);
    if (which == 0) return a_done_t.size();
    if (which == 1) return b_done_t.size();
    return c_done_n;
  endfunction

  task automatic wait_done(input int which, input int budget, input string tag);
    int n = 0;
    while (done_cnt(which) < 1 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic clear_a();
    a_rd_t.delete(); a_rd_r.delete(); a_rd_c.delete(); a_wr_t.delete();
    a_wr_r.delete(); a_wr_c.delete(); a_wr_p.delete(); a_done_t.delete();
  endtask

  task automatic pass_a();
    clear_a();
    start_a = 1'b1;
    s_cyc   = cyc;
    step();
    start_a = 1'b0;
    wait_done(0, 100, "a_timeout");
    repeat (4) step();
  endtask

  task automatic check_a_writes(input string tag, input int exp_pix);
    chk({tag, "_wr_count"}, a_wr_t.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < a_wr_t.size()) begin
        chk({tag, "_wr_row"}, a_wr_r[i], 1 + i / 2);
        chk({tag, "_wr_col"}, a_wr_c[i], 1 + i % 2);
        chk({tag, "_cl_pixel"}, a_wr_p[i], exp_pix);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    set_pix(0);
    repeat (3) step();
    chk("rst_strobes", {28'd0, rd_a, wr_a, busy_a, done_a}, 32'd0);
    chk("rst_addr", {arr_a, acr_a, arw_a, acw_a}, 32'd0);
    chk("rst_cl_pixel", 32'(cl_a), 32'd0);
    rst = 1'b0;
    step();

    // Basic 4x4 pass, uniform 100
    set_pix(100);
    pass_a();
    check_a_writes("p100", 100);
    chk("p100_rd_count", a_rd_t.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < a_rd_t.size()) begin
        chk("p100_rd_row", a_rd_r[i], i / 2);
        chk("p100_rd_col", a_rd_c[i], i % 2);
        if (i < a_wr_t.size()) chk("p100_rd_to_wr", a_wr_t[i] - a_rd_t[i], 3);
      end
    end
    if (a_rd_t.size() > 0) begin
      chk("p100_first_rd", a_rd_t[0], s_cyc + 1);
      if (a_done_t.size() > 0) chk("p100_done_lat", a_done_t[0] - a_rd_t[0], 16);
    end
    chk("p100_done_count", a_done_t.size(), 1);
    chk("p100_idle_busy", {31'd0, busy_a}, 32'd0);
    chk("p100_hold_cl", 32'(cl_a), 32'd100);
    chk("p100_hold_addr_w", {16'd0, arw_a, acw_a}, {16'd0, 8'd2, 8'd2});

    // Saturation extremes and a ramp window (sum 36 -> 4)
    set_pix(255);
    pass_a();
    check_a_writes("p255", 255);
    set_pix(0);
    pass_a();
    check_a_writes("p0", 0);
    for (int i = 0; i < 9; i++) pix[i] = 8'(i);
    pass_a();
    check_a_writes("ramp", 4);

    // start re-pulsed mid-pass and in the DONE cycle must be ignored
    set_pix(100);
    clear_a();
    start_a = 1'b1; s_cyc = cyc; step(); start_a = 1'b0;
    repeat (5) step();
    start_a = 1'b1; step(); start_a = 1'b0;
    repeat (10) step();
    chk("busy_done_cycle", {31'd0, done_a}, 32'd1);
    start_a = 1'b1; step(); start_a = 1'b0;
    repeat (10) step();
    check_a_writes("busy", 100);
    chk("busy_rd_count", a_rd_t.size(), 4);
    chk("busy_done_count", a_done_t.size(), 1);
    if (a_done_t.size() > 0) chk("busy_done_time", a_done_t[0], s_cyc + 17);

    // Reset during WAIT of window 2
    clear_a();
    start_a = 1'b1; s_cyc = cyc; step(); start_a = 1'b0;
    repeat (5) step();
    chk("rstmid_rd_count_before", a_rd_t.size(), 2);
    rst = 1'b1;
    step();
    chk("rstmid_strobes", {28'd0, rd_a, wr_a, busy_a, done_a}, 32'd0);
    chk("rstmid_addr", {arr_a, acr_a, arw_a, acw_a}, 32'd0);
    chk("rstmid_cl_pixel", 32'(cl_a), 32'd0);
    rst = 1'b0;
    repeat (8) step();
    chk("rstmid_wr_count", a_wr_t.size(), 1);
    chk("rstmid_rd_count_after", a_rd_t.size(), 2);
    chk("rstmid_done_count", a_done_t.size(), 0);
    pass_a();
    check_a_writes("restart", 100);
    if (a_rd_t.size() > 0) begin
      chk("restart_first_rd", a_rd_t[0], s_cyc + 1);
      chk("restart_first_addr", {a_rd_r[0][15:0], a_rd_c[0][15:0]}, 32'd0);
    end

    // RD_LAT=3 timing
    start_b = 1'b1; step(); start_b = 1'b0;
    wait_done(1, 100, "b_timeout");
    repeat (4) step();
    chk("lat3_wr_count", b_wr_t.size(), 4);
    chk("lat3_rd_count", b_rd_t.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < b_wr_t.size() && i < b_rd_t.size()) begin
        chk("lat3_rd_to_wr", b_wr_t[i] - b_rd_t[i], 5);
        chk("lat3_cl_pixel", b_wr_p[i], 100);
      end
      if (i < 3 && i + 1 < b_rd_t.size()) chk("lat3_rd_pitch", b_rd_t[i + 1] - b_rd_t[i], 6);
    end
    if (b_rd_t.size() > 0 && b_done_t.size() > 0) chk("lat3_done_lat", b_done_t[0] - b_rd_t[0], 24);
    chk("lat3_done_count", b_done_t.size(), 1);

    // Wide, short image: 254 windows in one row
    start_c = 1'b1; step(); start_c = 1'b0;
    wait_done(2, 1200, "c_timeout");
    repeat (10) step();
    chk("wide_wr_count", c_wr_n, 254);
    chk("wide_wr_maxcol", c_wr_maxcol, 254);
    chk("wide_rd_maxcol", c_rd_maxcol, 253);
    chk("wide_wr_row_bad", c_row_bad, 0);
    chk("wide_rd_row_bad", c_rd_row_bad, 0);
    chk("wide_col_sequence_bad", c_seq_bad, 0);
    chk("wide_cl_bad", c_cl_bad, 0);
    chk("wide_done_count", c_done_n, 1);
    chk("wide_busy_after", {31'd0, busy_c}, 32'd0);

    chk("rd_wr_overlap", overlap_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
